// File: rtl/pi_digit_stream.sv
`timescale 1ns/1ps
// Captures the pi engine's packed base-1000 result, converts each limb to three BCD digits
// by sequential double-dabble, and streams the digits MSB-first over valid/ready.
module pi_digit_stream #(
   parameter int L  = 10,
   parameter int N  = 10,
   parameter int W  = L * N,
   parameter int IW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  sum,
   output logic          busy,
   output logic          digit_valid,
   input  logic          digit_ready,
   output logic [3:0]    digit,
   output logic [IW-1:0] digit_index,
   output logic          digit_last,
   output logic          done,
   output logic          err
);

   localparam int CW = $clog2(L + 1);
   localparam int NW = $clog2(N + 1);

   typedef enum logic [2:0] {IDLE, CONV, EMIT0, EMIT1, EMIT2, DONE} state_t;

   state_t         state, state_nx;
   logic [W-1:0]   shreg;
   logic [L-1:0]   limb;
   logic [11:0]    bcd;
   logic [11:0]    bcd_adj;
   logic [CW-1:0]  bit_cnt;
   logic [NW-1:0]  limb_cnt;
   logic           bad;
   logic           emitting;
   logic           accept;
   logic           conv_last;
   logic           last_limb;

   function automatic logic [3:0] adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   assign emitting  = (state == EMIT0) || (state == EMIT1) || (state == EMIT2);
   assign accept    = emitting & digit_ready;
   assign conv_last = (bit_cnt == CW'(L - 1));
   assign last_limb = (limb_cnt == NW'(N - 1));
   assign bcd_adj   = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      busy        = (state != IDLE);
      digit_valid = emitting;
      digit_last  = (state == EMIT2) && last_limb;
      done        = (state == DONE);
      digit       = 4'h0;
      case (state)
         IDLE:  if (start) state_nx = CONV;
         CONV:  if (conv_last) state_nx = EMIT0;
         EMIT0: begin
            digit = bad ? 4'hF : bcd[11:8];
            if (accept) state_nx = EMIT1;
         end
         EMIT1: begin
            digit = bad ? 4'hF : bcd[7:4];
            if (accept) state_nx = EMIT2;
         end
         EMIT2: begin
            digit = bad ? 4'hF : bcd[3:0];
            if (accept) state_nx = last_limb ? DONE : CONV;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The limb shifts MSB-first straight into the BCD field as one combined register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg       <= '0;
         limb        <= '0;
         bcd         <= '0;
         bit_cnt     <= '0;
         limb_cnt    <= '0;
         bad         <= 1'b0;
         err         <= 1'b0;
         digit_index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg       <= sum << L;
                  limb        <= sum[W-1 -: L];
                  bcd         <= '0;
                  bit_cnt     <= '0;
                  limb_cnt    <= '0;
                  bad         <= 1'b0;
                  err         <= 1'b0;
                  digit_index <= '0;
               end
            end
            CONV: begin
               if ((bit_cnt == '0) && (limb > L'(999))) begin
                  bad <= 1'b1;
                  err <= 1'b1;
               end
               {bcd, limb} <= {bcd_adj, limb} << 1;
               bit_cnt     <= bit_cnt + CW'(1);
            end
            EMIT0, EMIT1: begin
               if (accept) digit_index <= digit_index + IW'(1);
            end
            EMIT2: begin
               if (accept) begin
                  digit_index <= digit_index + IW'(1);
                  if (!last_limb) begin
                     limb     <= shreg[W-1 -: L];
                     shreg    <= shreg << L;
                     limb_cnt <= limb_cnt + NW'(1);
                     bcd      <= '0;
                     bit_cnt  <= '0;
                     bad      <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pi_digit_stream.sv
`timescale 1ns/1ps
// Scoreboard bench for pi_digit_stream: stimulus queues hand-computed digits,
// a negedge monitor pops and compares every accepted digit and each done pulse.
module tb_pi_digit_stream;

   localparam int L  = 10;
   localparam int N  = 10;
   localparam int W  = L * N;
   localparam int IW = 5;
   localparam int ND = 3 * N;

   localparam logic [W-1:0] PI_SUM = {10'd3, 10'd141, 10'd592, 10'd653, 10'd589,
                                      10'd793, 10'd238, 10'd462, 10'd643, 10'd383};
   localparam logic [4*ND-1:0] PI_EXP = 120'h003141592653589793238462643383;
   localparam logic [W-1:0] OOR_SUM = {40'd0, 10'd1023, 50'd0};
   localparam logic [4*ND-1:0] OOR_EXP = 120'h000000000000FFF000000000000000;
   localparam logic [W-1:0] CLN_SUM = {10'd999, 10'd0, 10'd1, 10'd10, 10'd100,
                                       10'd500, 10'd505, 10'd250, 10'd7, 10'd42};
   localparam logic [4*ND-1:0] CLN_EXP = 120'h999000001010100500505250007042;

   typedef struct packed {
      logic [3:0]    d;
      logic [IW-1:0] idx;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  sum;
   logic          busy;
   logic          digit_valid;
   logic          digit_ready;
   logic [3:0]    digit;
   logic [IW-1:0] digit_index;
   logic          digit_last;
   logic          done;
   logic          err;

   exp_t          sb[$];
   int            checks = 0;
   int            failures = 0;
   int            done_cnt = 0;
   int            cyc = 0;
   int            last_acc_cyc = 0;
   int            done_cyc = 0;
   int            start_cyc = 0;
   logic          exp_err = 1'b0;
   bit            bp_mode = 1'b0;
   bit            held_v = 1'b0;
   logic [3:0]    held_d;
   logic [IW-1:0] held_i;

   pi_digit_stream #(.L(L), .N(N), .W(W), .IW(IW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .sum         (sum),
      .busy        (busy),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .digit       (digit),
      .digit_index (digit_index),
      .digit_last  (digit_last),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Ready is either tied high or pseudo-random with a forced 20-cycle stall every 40 cycles.
   initial begin
      int stall = 0;
      int bp_cyc = 0;
      digit_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            bp_cyc++;
            if (stall > 0) begin
               digit_ready = 1'b0;
               stall--;
            end else if ((bp_cyc % 40) == 5) begin
               digit_ready = 1'b0;
               stall = 19;
            end else begin
               digit_ready = ($urandom_range(0, 2) != 0);
            end
         end else begin
            digit_ready = 1'b1;
         end
      end
   end

   // Monitor: stall stability, scoreboard pops on accept, done pulse checks.
   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            checkOutput("stall_valid", {31'd0, digit_valid}, 32'd1);
            checkOutput("stall_digit", {28'd0, digit}, {28'd0, held_d});
            checkOutput("stall_index", {27'd0, digit_index}, {27'd0, held_i});
         end
         if (digit_valid && digit_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_digit", {27'd0, digit_index}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("digit", {28'd0, digit}, {28'd0, e.d});
               checkOutput("digit_index", {27'd0, digit_index}, {27'd0, e.idx});
               checkOutput("digit_last", {31'd0, digit_last}, {31'd0, e.last});
               if (e.last) last_acc_cyc = cyc;
            end
         end
         held_v = digit_valid && !digit_ready;
         held_d = digit;
         held_i = digit_index;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            checkOutput("sb_empty_at_done", sb.size(), 32'd0);
            checkOutput("done_after_last", cyc - last_acc_cyc, 32'd1);
            checkOutput("err_at_done", {31'd0, err}, {31'd0, exp_err});
            checkOutput("valid_low_at_done", {31'd0, digit_valid}, 32'd0);
         end
      end
   end

   task automatic applyStimulus(input logic [W-1:0] s, input logic [4*ND-1:0] expd,
                                input logic e_err, input bit chk_lat);
      @(posedge clk);
      #1;
      sum   = s;
      start = 1'b1;
      for (int i = 0; i < ND; i++) begin
         exp_t e;
         e.d    = expd[4*ND-1-4*i -: 4];
         e.idx  = IW'(i);
         e.last = (i == ND - 1);
         sb.push_back(e);
      end
      exp_err = e_err;
      @(posedge clk);
      #1;
      start     = 1'b0;
      start_cyc = cyc;
      checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
      checkOutput("err_clear_on_start", {31'd0, err}, 32'd0);
      if (chk_lat) begin
         repeat (L - 1) @(posedge clk);
         #1;
         checkOutput("valid_before_latency", {31'd0, digit_valid}, 32'd0);
         @(posedge clk);
         #1;
         checkOutput("valid_at_latency", {31'd0, digit_valid}, 32'd1);
         checkOutput("first_index", {27'd0, digit_index}, 32'd0);
      end
   endtask

   task automatic waitDone(input int budget);
      int base = done_cnt;
      int n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("done_pulse_seen", done_cnt - base, 32'd1);
      @(negedge clk);
      #1;
      checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
      checkOutput("busy_low_after_done", {31'd0, busy}, 32'd0);
      checkOutput("done_single", done_cnt - base, 32'd1);
   endtask

   task automatic waitIndex(input logic [IW-1:0] idx, input int budget);
      int n = 0;
      while (!(digit_valid && digit_index == idx) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("reached_index", {27'd0, digit_index}, {27'd0, idx});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      rst   = 1'b1;
      start = 1'b0;
      sum   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_valid", {31'd0, digit_valid}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);

      // Async reset during conversion, before any digit is queued.
      @(posedge clk);
      #1;
      sum   = PI_SUM;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("async_reset_valid", {31'd0, digit_valid}, 32'd0);
      checkOutput("async_reset_done", {31'd0, done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_hold_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_hold_valid", {31'd0, digit_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] pi stream, ready high");
      applyStimulus(PI_SUM, PI_EXP, 1'b0, 1'b1);
      waitDone(400);
      checkOutput("stream_cycles", done_cyc - start_cyc, N * (L + 3));
      checkOutput("pi_err", {31'd0, err}, 32'd0);

      $display("[TB] pi stream, backpressure");
      bp_mode = 1'b1;
      applyStimulus(PI_SUM, PI_EXP, 1'b0, 1'b1);
      waitDone(5000);
      bp_mode = 1'b0;

      $display("[TB] out-of-range limb");
      applyStimulus(OOR_SUM, OOR_EXP, 1'b1, 1'b0);
      waitDone(400);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("err_sticky_idle", {31'd0, err}, 32'd1);
      applyStimulus(CLN_SUM, CLN_EXP, 1'b0, 1'b0);
      waitDone(400);

      $display("[TB] start while busy");
      applyStimulus(PI_SUM, PI_EXP, 1'b0, 1'b0);
      waitIndex(IW'(6), 400);
      @(posedge clk);
      #1;
      sum   = CLN_SUM;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(400);
      base = done_cnt;
      repeat (20) @(negedge clk);
      #1;
      checkOutput("no_restart_done", done_cnt - base, 32'd0);
      checkOutput("no_restart_busy", {31'd0, busy}, 32'd0);

      $display("[TB] reset mid-stream");
      applyStimulus(PI_SUM, PI_EXP, 1'b0, 1'b0);
      waitIndex(IW'(16), 400);
      base = done_cnt;
      rst = 1'b1;
      #1;
      checkOutput("mid_reset_valid", {31'd0, digit_valid}, 32'd0);
      checkOutput("mid_reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_reset_index", {27'd0, digit_index}, 32'd0);
      checkOutput("mid_reset_digit", {28'd0, digit}, 32'd0);
      sb.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      checkOutput("no_done_after_abort", done_cnt - base, 32'd0);
      applyStimulus(CLN_SUM, CLN_EXP, 1'b0, 1'b1);
      waitDone(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pi_digit_stream.md
Name: pi_digit_stream

Overview:
- Downstream consumer of the big-number pi engine (controll).
- Captures its packed base-1000 result bus `sum`: N limbs of L bits each, most significant limb at the top.
- Converts each limb to three decimal digits with a sequential double-dabble.
- Streams the digits, most significant first, over a valid/ready interface to the VGA text renderer.

Parameters:
L, 10, bits per limb (each limb holds 0..999)
N, 10, number of limbs
W, L*N, width of captured sum bus
IW, 5, width of digit_index (must satisfy 2^IW >= 3*N)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to capture sum and begin streaming
sum  in  W  packed result; limb k = sum[W-1-k*L -: L], k=0 is most significant
busy  out  1  high from the cycle after start is accepted until done
digit_valid  out  1  digit/digit_index/digit_last are valid
digit_ready  in  1  downstream accepts the digit when high with digit_valid at a rising edge
digit  out  4  BCD digit 0..9, or 4'hF for an out-of-range limb
digit_index  out  IW  position of digit in stream, 0..3N-1
digit_last  out  1  high with the final digit (index 3N-1)
done  out  1  one-cycle pulse after the last digit is accepted
err  out  1  sticky: some limb of the current capture was >999; cleared by the next accepted start

Behaviour:
- Clock and reset: one clock (clk); rst asynchronous, active-high.
- Reset values: busy=0, digit_valid=0, digit=0, digit_index=0, digit_last=0, done=0, err=0; state IDLE.
- States: IDLE, CONV, EMIT0 (hundreds), EMIT1 (tens), EMIT2 (ones), DONE.
- IDLE:
  - start=1 at edge e0: capture sum into a W-bit shift register, load limb 0 into the converter, clear err, clear limb counter and digit_index.
  - Go to CONV; busy=1 after e0.
- CONV:
  - Exactly L cycles of double-dabble on a 12-bit BCD field: add 3 to any nibble >=5, then shift left one bit, MSB of the limb first.
  - Before the first shift, if limb >999, set an internal bad flag and err=1.
  - After the Lth shift edge go to EMIT0. First digit_valid is visible after edge e0+L.
- EMIT0/1/2:
  - digit_valid=1. digit = hundreds/tens/ones nibble, or 4'hF when bad.
  - Outputs are held stable while digit_valid=1 and digit_ready=0; no limit on stall length.
  - Accept = digit_valid & digit_ready at an edge. On accept, digit_index increments and the state advances.
  - After an EMIT2 accept:
    - If more limbs remain: shift the next limb in, enter CONV; digit_valid drops for L cycles.
    - Otherwise: enter DONE.
- digit_last=1 only in EMIT2 of limb N-1.
- DONE: done=1 for exactly one cycle, digit_valid=0, busy=0 on exit; return to IDLE.
- start while busy is ignored; it neither recaptures nor restarts. start in the DONE cycle is also ignored.
- sum changing after capture has no effect on the stream.
- rst asserted mid-stream aborts at once to the reset values. A partially presented digit is withdrawn with no done pulse.
- digit_ready is ignored when digit_valid=0.
- Throughput with digit_ready tied high: L+3 cycles per limb; full stream N*(L+3) cycles, then the done pulse.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; hold 3 cycles -> still IDLE, busy=0.
- Pi stream:
  - Stimulus: sum limbs 3,141,592,653,589,793,238,462,643,383; digit_ready=1; pulse start.
  - Required: first digit_valid after 10 edges; 30 digits 0,0,3,1,4,1,5,9,2,6,5,3,5,8,9,7,9,3,2,3,8,4,6,2,6,4,3,3,8,3.
  - Indices 0..29; digit_last only on index 29; done one cycle later; err=0.
- Backpressure:
  - Stimulus: same input; digit_ready toggled pseudo-randomly, including 20-cycle stalls.
  - Required: identical digit sequence; digit/index stable throughout every stall; no digit duplicated or dropped.
- Out of range:
  - Stimulus: limb 4 = 1023, other limbs 0.
  - Required: digits 12..14 = F,F,F; all other digits 0; err=1 through done and into IDLE.
  - Next start with a clean bus -> err=0.
- Start while busy: second start pulse with a different sum during limb 2 -> stream unchanged, single done pulse.
- Reset mid-stream:
  - Stimulus: rst during EMIT1 of limb 5.
  - Required: digit_valid drops immediately; no done pulse; a new start afterwards streams from index 0 correctly.
